// File: rtl/counter_64.sv
// Free-running cycle counter with start/end timestamp capture and elapsed-cycle output.
// Optional watchdog enabled by defining COUNTER_64_TIMEOUT_EN.
module counter_64 #(
    parameter int WIDTH         = 64,
    parameter int TIMEOUT_LIMIT = 6000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             increment,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mark_start,
    input  logic             mark_end,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] start_cycle,
    output logic [WIDTH-1:0] end_cycle,
    output logic [WIDTH-1:0] elapsed,
    output logic             wrapped,
    output logic             timeout
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             wrapped_q, wrapped_d;

    always_comb begin
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (clear) begin
            count_d   = '0;
            wrapped_d = 1'b0;
        end else if (load) begin
            count_d = load_value;
        end else if (increment) begin
            count_d = count_q + 1'b1;
            if (count_q == {WIDTH{1'b1}}) begin
                wrapped_d = 1'b1;
            end
        end
    end

    // Marks always sample the pre-update count, whatever the count controls do.
    always_comb begin
        start_d = mark_start ? count_q : start_q;
        end_d   = mark_end   ? count_q : end_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            start_q   <= '0;
            end_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            start_q   <= start_d;
            end_q     <= end_d;
            wrapped_q <= wrapped_d;
        end
    end

`ifdef COUNTER_64_TIMEOUT_EN
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_LIMIT);

    logic timeout_q, timeout_d;

    always_comb begin
        timeout_d = timeout_q;
        if (clear) begin
            timeout_d = 1'b0;
        end else if (count_q > LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign count       = count_q;
    assign start_cycle = start_q;
    assign end_cycle   = end_q;
    assign elapsed     = end_q - start_q;
    assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_counter_64.sv
// Directed bench for counter_64: reset, counting, marks, wrap, control collisions,
// asynchronous reset and the optional watchdog.
module tb_counter_64;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         increment;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         mark_start;
    logic         mark_end;
    logic [W-1:0] count;
    logic [W-1:0] start_cycle;
    logic [W-1:0] end_cycle;
    logic [W-1:0] elapsed;
    logic         wrapped;
    logic         timeout;

    int tests;
    int fails;

    counter_64 #(.WIDTH(W), .TIMEOUT_LIMIT(6000)) dut (
        .clk        (clk),
        .rst        (rst),
        .increment  (increment),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .mark_start (mark_start),
        .mark_end   (mark_end),
        .count      (count),
        .start_cycle(start_cycle),
        .end_cycle  (end_cycle),
        .elapsed    (elapsed),
        .wrapped    (wrapped),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        increment  = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        mark_start = 1'b0;
        mark_end   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        tests++; if (count !== 64'd0) begin fails++; $display("FAIL reset_count got=%0h exp=0", count); end
        tests++; if (elapsed !== 64'd0) begin fails++; $display("FAIL reset_elapsed got=%0h exp=0", elapsed); end
        tests++; if (wrapped !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", wrapped, timeout); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_count();
        increment = 1'b1;
        repeat (10) step();
        increment = 1'b0;
        tests++; if (count !== 64'd10) begin fails++; $display("FAIL count10 got=%0d exp=10", count); end
        tests++; if (start_cycle !== 64'd0 || end_cycle !== 64'd0) begin fails++; $display("FAIL count10_marks got=%0d/%0d exp=0/0", start_cycle, end_cycle); end
        tests++; if (elapsed !== 64'd0) begin fails++; $display("FAIL count10_elapsed got=%0d exp=0", elapsed); end
        tests++; if (wrapped !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL count10_flags got=%b%b exp=00", wrapped, timeout); end
    endtask

    task automatic test_marks();
        logic [W-1:0] exp;
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp = '0;
        increment = 1'b1;
        for (int i = 0; i < 50; i++) begin
            mark_start = (exp == 64'd5);
            mark_end   = (exp == 64'd47);
            step();
            exp = exp + 1;
        end
        idle_inputs();
        tests++; if (count !== exp) begin fails++; $display("FAIL marks_count got=%0d exp=%0d", count, exp); end
        tests++; if (start_cycle !== 64'd5) begin fails++; $display("FAIL marks_start got=%0d exp=5", start_cycle); end
        tests++; if (end_cycle !== 64'd47) begin fails++; $display("FAIL marks_end got=%0d exp=47", end_cycle); end
        tests++; if (elapsed !== 64'd42) begin fails++; $display("FAIL marks_elapsed got=%0d exp=42", elapsed); end
    endtask

    task automatic test_wrap();
        load = 1'b1;
        load_value = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        load = 1'b0;
        tests++; if (count !== 64'hFFFF_FFFF_FFFF_FFFE || wrapped !== 1'b0) begin fails++; $display("FAIL wrap_load got=%0h/%b exp=fffffffffffffffe/0", count, wrapped); end
        increment = 1'b1;
        step();
        tests++; if (count !== 64'hFFFF_FFFF_FFFF_FFFF || wrapped !== 1'b0) begin fails++; $display("FAIL wrap_max got=%0h/%b exp=ffffffffffffffff/0", count, wrapped); end
        step();
        increment = 1'b0;
        tests++; if (count !== 64'd0 || wrapped !== 1'b1) begin fails++; $display("FAIL wrap_roll got=%0h/%b exp=0/1", count, wrapped); end
        step();
        tests++; if (wrapped !== 1'b1) begin fails++; $display("FAIL wrap_sticky got=%b exp=1", wrapped); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        tests++; if (count !== 64'd0 || wrapped !== 1'b0) begin fails++; $display("FAIL wrap_clear got=%0h/%b exp=0/0", count, wrapped); end
        tests++; if (start_cycle !== 64'd5 || end_cycle !== 64'd47) begin fails++; $display("FAIL wrap_clear_marks got=%0d/%0d exp=5/47", start_cycle, end_cycle); end
    endtask

    task automatic test_elapsed_wrap();
        load = 1'b1;
        load_value = 64'd20;
        step();
        load = 1'b0;
        mark_end = 1'b1;
        step();
        mark_end = 1'b0;
        load = 1'b1;
        load_value = 64'd30;
        step();
        load = 1'b0;
        mark_start = 1'b1;
        step();
        mark_start = 1'b0;
        tests++; if (elapsed !== 64'hFFFF_FFFF_FFFF_FFF6) begin fails++; $display("FAIL elapsed_neg got=%0h exp=fffffffffffffff6", elapsed); end
        mark_start = 1'b1;
        mark_end   = 1'b1;
        step();
        idle_inputs();
        tests++; if (start_cycle !== 64'd30 || end_cycle !== 64'd30 || elapsed !== 64'd0) begin fails++; $display("FAIL mark_both got=%0d/%0d/%0d exp=30/30/0", start_cycle, end_cycle, elapsed); end
    endtask

    task automatic test_collision();
        load = 1'b1;
        load_value = 64'd100;
        step();
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 64'd777;
        increment  = 1'b1;
        mark_start = 1'b1;
        step();
        idle_inputs();
        tests++; if (count !== 64'd0) begin fails++; $display("FAIL collide_count got=%0d exp=0", count); end
        tests++; if (start_cycle !== 64'd100) begin fails++; $display("FAIL collide_start got=%0d exp=100", start_cycle); end
        load = 1'b1;
        load_value = 64'd55;
        increment = 1'b1;
        step();
        idle_inputs();
        tests++; if (count !== 64'd55) begin fails++; $display("FAIL load_over_inc got=%0d exp=55", count); end
    endtask

    task automatic test_async_reset();
        load = 1'b1;
        load_value = 64'd300;
        mark_end = 1'b1;
        step();
        idle_inputs();
        increment = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        tests++; if (count !== 64'd0 || start_cycle !== 64'd0 || end_cycle !== 64'd0) begin fails++; $display("FAIL async_rst_regs got=%0d/%0d/%0d exp=0/0/0", count, start_cycle, end_cycle); end
        tests++; if (elapsed !== 64'd0 || wrapped !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL async_rst_outs got=%0d/%b/%b exp=0/0/0", elapsed, wrapped, timeout); end
        step();
        rst = 1'b1;
        repeat (3) step();
        increment = 1'b0;
        tests++; if (count !== 64'd3) begin fails++; $display("FAIL async_rst_resume got=%0d exp=3", count); end
    endtask

    task automatic test_timeout();
        logic exp_to;
`ifdef COUNTER_64_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        load = 1'b1;
        load_value = 64'd5999;
        step();
        load = 1'b0;
        increment = 1'b1;
        step();
        tests++; if (count !== 64'd6000 || timeout !== 1'b0) begin fails++; $display("FAIL to_6000 got=%0d/%b exp=6000/0", count, timeout); end
        step();
        tests++; if (count !== 64'd6001 || timeout !== 1'b0) begin fails++; $display("FAIL to_6001 got=%0d/%b exp=6001/0", count, timeout); end
        step();
        tests++; if (count !== 64'd6002 || timeout !== exp_to) begin fails++; $display("FAIL to_rise got=%0d/%b exp=6002/%b", count, timeout, exp_to); end
        increment = 1'b0;
        load = 1'b1;
        load_value = 64'd1;
        step();
        load = 1'b0;
        step();
        tests++; if (timeout !== exp_to) begin fails++; $display("FAIL to_sticky got=%b exp=%b", timeout, exp_to); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_clear got=%b exp=0", timeout); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_count();
        test_marks();
        test_wrap();
        test_elapsed_wrap();
        test_collision();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
